i2s_tx_16: RTL and testbench
============================

# i2s_tx_16

Stereo I2S transmitter: accepts 16-bit left/right sample pairs through a valid/ready handshake and serialises them onto a 64fs I2S link with 32-bit slots, MSB-first and one-BCK delayed from LRCK. It is the transmit counterpart of the I2S capture path. It feeds DACs and downstream I2S receivers from the 16-bit sample domain. It is clocked directly by the link bit clock, `bck`.

## Interface
- SAMPLE_BITS, 16, sample width per channel; fixed at 16 in this revision.
- SLOT_BITS, 32, BCK periods per channel slot; the frame is 2*SLOT_BITS = 64 BCK.
- bck  input  1  bit clock (64fs); the only clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- s_valid  input  1  sample pair valid.
- s_ready  output  1  block can accept a pair; equals !stage_full.
- s_left  input  16  left sample, two's complement.
- s_right  input  16  right sample, two's complement.
- lrck_out  output  1  I2S word select; 0 = left, 1 = right.
- data_out  output  1  I2S serial data.
- underrun  output  1  one-cycle pulse when a frame starts with no staged pair.
- underrun_cnt  output  8  saturating count of underruns.

## Operation
- Storage:
  - stage register holds {left, right} and stage_full.
  - frame register holds the pair currently being shifted.
- Accept: on posedge bck, when s_valid && s_ready, the stage register captures s_left/s_right and stage_full is set.
- Bit counter cnt is 6 bits, 0..63. It increments by 1 per posedge in RUN and wraps 63 -> 0.
- FSM:
  - IDLE (after reset): cnt is held at 63, lrck_out = 0, data_out = 0. If stage_full = 1 at a posedge, the frame loads, cnt goes to 0, and the FSM enters RUN.
  - RUN: continuous. The FSM returns to IDLE only on reset.
- Frame load happens at each posedge where cnt = 63 (in RUN), or on the IDLE exit edge:
  - stage_full = 1: frame <= stage, and stage_full clears.
  - stage_full = 0: frame <= 0, and underrun pulses for one cycle. underrun_cnt increments, saturating at 255. The IDLE exit never counts as an underrun.
- Simultaneous load and accept: if the stage transfers to the frame and a new pair is accepted on the same edge, the new pair lands in stage and stage_full stays 1. s_ready is registered-full based, so an accept only happens while the stage was empty. A load edge with an empty stage and an accept therefore still sends zeros (underrun), and the accepted pair goes to stage for the next frame.
- Serial map, as a function of cnt:
  - lrck_out = 1 for cnt 31..62; lrck_out = 0 for cnt 63 and 0..30.
  - data_out = left[15-cnt] for cnt 0..15; 0 for cnt 16..31.
  - data_out = right[47-cnt] for cnt 32..47; 0 for cnt 48..63.
- Result: lrck_out changes exactly one BCK before each MSB, which is I2S alignment.

## Timing
- State (cnt, FSM, stage, frame, underrun, underrun_cnt) updates on posedge bck.
- lrck_out and data_out are registered on negedge bck from the cnt and frame values set by the preceding posedge. The receiver samples them on the next posedge.
- Output latency:
  - First frame: the left MSB appears on data_out at the negedge following the IDLE-exit posedge.
  - Accept to MSB on air is therefore 1.5 BCK when idle.
  - In RUN, a pair accepted during frame N goes on air in frame N+1 if accepted before the cnt = 63 edge.
- Throughput: one pair per 64 BCK. s_ready deasserts the cycle after an accept and reasserts the cycle after the stage transfers.
- Reset, asynchronous on rst_n low:
  - FSM = IDLE, cnt = 63, stage_full = 0, frame = 0.
  - lrck_out = 0, data_out = 0, underrun = 0, underrun_cnt = 0, s_ready = 1.
  - Reset mid-frame truncates the frame immediately. No partial word is resumed.
- underrun is high only during the cycle after the load edge at which the stage was empty.

## Test plan
- Reset, then one pair L=16'hA5C3, R=16'h0F01:
  - data_out over cnt 0..15 = 1010010111000011, cnt 16..31 = 0.
  - cnt 32..47 = 0000111100000001.
  - lrck_out rises at cnt 31 and falls at cnt 63.
  - underrun pulses at the next frame start, underrun_cnt = 1.
- Back-to-back stream of 4 pairs with s_valid always 1: s_ready toggles once per frame, there are 4 contiguous frames with no underrun, then zeros with underrun = 1.
- Accept exactly on the cnt = 63 edge while the stage is full: the stage transfers and the new pair is held. No pair is lost or duplicated across 3 frames.
- 300 frames with no input after the first pair: underrun_cnt saturates at 255. lrck_out keeps toggling with period 64 BCK.
- Assert rst_n low at cnt = 40 mid-right-slot:
  - outputs go to 0 immediately.
  - after release, the block sits in IDLE until the next accept.
  - the first frame then starts cleanly with left MSB at cnt 0.
- Negative full-scale L=16'h8000, R=16'h7FFF: the MSBs are 1 and 0 respectively, checked against a reference I2S receiver model sampling on posedge.

Source files
------------

// File: rtl/i2s_tx_16.sv
// i2s_tx_16: stereo 16-bit I2S transmitter, 64fs frame of two 32-bit slots,
// MSB one BCK after each LRCK edge; state on posedge, pins launched on negedge.
module i2s_tx_16 #(
  parameter int SAMPLE_BITS = 16,
  parameter int SLOT_BITS   = 32
) (
  input  logic                   bck,
  input  logic                   rst_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [SAMPLE_BITS-1:0] s_left,
  input  logic [SAMPLE_BITS-1:0] s_right,
  output logic                   lrck_out,
  output logic                   data_out,
  output logic                   underrun,
  output logic [7:0]             underrun_cnt
);
  localparam logic [5:0] LAST = 6'(2 * SLOT_BITS - 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] stage_q, stage_d, frame_q, frame_d;
  logic        full_q, full_d, underrun_q, underrun_d, lrck_d, data_d;
  logic [7:0]  ucnt_q, ucnt_d;
  logic        accept, load;
  assign s_ready      = !full_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = ucnt_q;
  assign accept       = s_valid && !full_q;
  assign load         = (state_q == IDLE) ? full_q : (cnt_q == LAST);
  always_comb begin
    state_d    = (state_q == IDLE && !full_q) ? IDLE : RUN;
    cnt_d      = (state_q == IDLE) ? (full_q ? 6'd0 : LAST) : cnt_q + 6'd1;
    full_d     = accept || (full_q && !load);
    stage_d    = accept ? {s_left, s_right} : stage_q;
    frame_d    = load ? (full_q ? stage_q : 32'd0) : frame_q;
    underrun_d = state_q == RUN && cnt_q == LAST && !full_q;
    ucnt_d     = (underrun_d && ucnt_q != 8'hFF) ? ucnt_q + 8'd1 : ucnt_q;
    lrck_d     = cnt_q >= 6'd31 && cnt_q <= 6'd62;
    // bits 16..31 and 48..63 of the frame are zero padding; otherwise walk the pair MSB-first
    data_d     = !cnt_q[4] && frame_q[{~cnt_q[5], ~cnt_q[3:0]}];
  end
  always_ff @(posedge bck or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= LAST;
      stage_q    <= '0;
      frame_q    <= '0;
      full_q     <= 1'b0;
      underrun_q <= 1'b0;
      ucnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stage_q    <= stage_d;
      frame_q    <= frame_d;
      full_q     <= full_d;
      underrun_q <= underrun_d;
      ucnt_q     <= ucnt_d;
    end
  end
  always_ff @(negedge bck or negedge rst_n) begin
    if (!rst_n) begin
      lrck_out <= 1'b0;
      data_out <= 1'b0;
    end else begin
      lrck_out <= lrck_d;
      data_out <= data_d;
    end
  end
endmodule

// File: tb/tb_i2s_tx_16.sv
// tb_i2s_tx_16: directed bench for i2s_tx_16 with a posedge-sampling I2S receiver
// that rebuilds each frame's left/right words from the wire.
module tb_i2s_tx_16;
  logic        bck, rst_n, s_valid, s_ready, lrck_out, data_out, underrun;
  logic [15:0] s_left, s_right;
  logic [7:0]  underrun_cnt;
  int          total, passes, fi, fn, rdy_cnt;
  logic [15:0] fl [8];
  logic [15:0] fr [8];
  logic [63:0] lr, dd;
  logic        u0, u1, bad;
  localparam logic [63:0] LR_EXP = 64'h7FFF_FFFF_8000_0000;

  i2s_tx_16 dut (
    .bck(bck), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_left(s_left), .s_right(s_right), .lrck_out(lrck_out), .data_out(data_out),
    .underrun(underrun), .underrun_cnt(underrun_cnt)
  );

  initial bck = 1'b0;
  always #5 bck = ~bck;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic start_feed(input int n);
    fi = 0;
    fn = n;
    s_valid = 1'b1;
    s_left = fl[0];
    s_right = fr[0];
  endtask

  // one BCK: handshake decided by values held across the posedge, then observe pins after the negedge
  task automatic step();
    logic hs;
    hs = s_valid && s_ready;
    @(negedge bck);
    #1;
    if (hs) begin
      fi++;
      s_valid = fi < fn;
      if (fi < fn) begin
        s_left = fl[fi];
        s_right = fr[fi];
      end
    end
    rdy_cnt += int'(s_ready);
  endtask

  task automatic capture_frame(output logic [63:0] l, output logic [63:0] d,
                               output logic ur0, output logic ur1);
    l = '0;
    d = '0;
    ur0 = 1'b0;
    ur1 = 1'b0;
    for (int i = 0; i < 64; i++) begin
      step();
      l[i] = lrck_out;
      d[i] = data_out;
      if (i == 0) ur0 = underrun;
      if (i == 1) ur1 = underrun;
    end
  endtask

  function automatic logic [15:0] rx_word(input logic [63:0] d, input int base);
    logic [15:0] w;
    for (int i = 0; i < 16; i++) w[15-i] = d[base+i];
    return w;
  endfunction

  initial begin
    total = 0;
    passes = 0;
    fi = 0;
    fn = 0;
    rdy_cnt = 0;
    rst_n = 1'b0;
    s_valid = 1'b0;
    s_left = '0;
    s_right = '0;
    repeat (3) @(negedge bck);
    #1;
    check("rst_ready", 64'(s_ready), 64'd1);
    check("rst_lrck", 64'(lrck_out), 64'd0);
    check("rst_data", 64'(data_out), 64'd0);
    check("rst_underrun", 64'(underrun), 64'd0);
    check("rst_ucnt", 64'(underrun_cnt), 64'd0);
    rst_n = 1'b1;
    repeat (2) step();
    check("idle_lrck", 64'(lrck_out), 64'd0);

    fl[0] = 16'hA5C3;
    fr[0] = 16'h0F01;
    start_feed(1);
    step();
    check("ready_after_accept", 64'(s_ready), 64'd0);
    capture_frame(lr, dd, u0, u1);
    check("f1_left", 64'(rx_word(dd, 0)), 64'h A5C3);
    check("f1_right", 64'(rx_word(dd, 32)), 64'h0F01);
    check("f1_left_pad", 64'(dd[31:16]), 64'd0);
    check("f1_right_pad", 64'(dd[63:48]), 64'd0);
    check("f1_lrck", lr, LR_EXP);
    check("f1_no_underrun", 64'(u0), 64'd0);
    capture_frame(lr, dd, u0, u1);
    check("f2_zero", dd, 64'd0);
    check("f2_lrck", lr, LR_EXP);
    check("f2_underrun", 64'(u0), 64'd1);
    check("f2_underrun_one_cycle", 64'(u1), 64'd0);
    check("f2_ucnt", 64'(underrun_cnt), 64'd1);

    fl[0] = 16'h1234; fr[0] = 16'hFEDC;
    fl[1] = 16'h8001; fr[1] = 16'h7FFE;
    fl[2] = 16'h00FF; fr[2] = 16'hFF00;
    fl[3] = 16'hC33C; fr[3] = 16'h5AA5;
    start_feed(4);
    capture_frame(lr, dd, u0, u1);
    check("f3_zero_despite_accept", dd, 64'd0);
    check("f3_underrun", 64'(u0), 64'd1);
    for (int k = 0; k < 4; k++) begin
      rdy_cnt = 0;
      capture_frame(lr, dd, u0, u1);
      check($sformatf("bb%0d_left", k), 64'(rx_word(dd, 0)), 64'(fl[k]));
      check($sformatf("bb%0d_right", k), 64'(rx_word(dd, 32)), 64'(fr[k]));
      check($sformatf("bb%0d_no_underrun", k), 64'(u0), 64'd0);
      check($sformatf("bb%0d_ready_cycles", k), 64'(rdy_cnt), (k < 3) ? 64'd1 : 64'd64);
    end
    capture_frame(lr, dd, u0, u1);
    check("f8_zero", dd, 64'd0);
    check("f8_underrun", 64'(u0), 64'd1);
    check("f8_ucnt", 64'(underrun_cnt), 64'd3);

    bad = 1'b0;
    repeat (260) begin
      capture_frame(lr, dd, u0, u1);
      bad |= (lr != LR_EXP) || (dd != 64'd0) || !u0;
    end
    check("long_idle_frames", 64'(bad), 64'd0);
    check("ucnt_saturated", 64'(underrun_cnt), 64'd255);
    capture_frame(lr, dd, u0, u1);
    check("sat_still_pulses", 64'(u0), 64'd1);
    check("ucnt_held", 64'(underrun_cnt), 64'd255);
    check("sat_lrck", lr, LR_EXP);

    fl[0] = 16'hFFFF;
    fr[0] = 16'hFFFF;
    start_feed(1);
    capture_frame(lr, dd, u0, u1);
    check("pre_rst_underrun", 64'(u0), 64'd1);
    repeat (20) step();
    fl[0] = 16'h1234;
    fr[0] = 16'h4321;
    start_feed(1);
    repeat (21) step();
    check("cnt40_lrck", 64'(lrck_out), 64'd1);
    check("cnt40_data", 64'(data_out), 64'd1);
    check("cnt40_ready", 64'(s_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_lrck", 64'(lrck_out), 64'd0);
    check("midrst_data", 64'(data_out), 64'd0);
    check("midrst_ready", 64'(s_ready), 64'd1);
    check("midrst_ucnt", 64'(underrun_cnt), 64'd0);
    repeat (2) @(negedge bck);
    #1;
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (10) begin
      step();
      bad |= lrck_out || data_out || !s_ready || underrun;
    end
    check("post_rst_idle", 64'(bad), 64'd0);

    fl[0] = 16'h8000;
    fr[0] = 16'h7FFF;
    start_feed(1);
    step();
    capture_frame(lr, dd, u0, u1);
    check("neg_left_msb", 64'(dd[0]), 64'd1);
    check("pos_right_msb", 64'(dd[32]), 64'd0);
    check("neg_left", 64'(rx_word(dd, 0)), 64'h8000);
    check("pos_right", 64'(rx_word(dd, 32)), 64'h7FFF);
    check("neg_lrck", lr, LR_EXP);
    check("neg_no_underrun", 64'(u0), 64'd0);
    check("neg_ucnt", 64'(underrun_cnt), 64'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
